// File: rtl/controller_pkg.sv
// Shared encodings for the processor control FSM: opcodes, instruction field
// positions, state codes and the default empty-stack pointer value.
package controller_pkg;

    localparam logic [31:0] STACK_TOP_DEFAULT = 32'h0000_FFFF;

    localparam logic [5:0] OP_ALU    = 6'h00;
    localparam logic [5:0] OP_SHIFT  = 6'h01;
    localparam logic [5:0] OP_LOAD   = 6'h02;
    localparam logic [5:0] OP_STORE  = 6'h03;
    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_JMP    = 6'h05;
    localparam logic [5:0] OP_CALL   = 6'h06;
    localparam logic [5:0] OP_RET    = 6'h07;
    localparam logic [5:0] OP_MOV    = 6'h0A;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int FA_MSB  = 25;
    localparam int FA_LSB  = 21;
    localparam int FB_MSB  = 20;
    localparam int FB_LSB  = 16;
    localparam int FC_MSB  = 15;
    localparam int FC_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 3;
    localparam int FN_LSB  = 0;

    typedef enum logic [4:0] {
        S_RESET   = 5'd0,
        S_FETCH   = 5'd1,
        S_ALU_A   = 5'd2,
        S_ALU_B   = 5'd3,
        S_ALU_WB  = 5'd4,
        S_LD_ADDR = 5'd5,
        S_LD_DATA = 5'd6,
        S_ST_ADDR = 5'd7,
        S_ST_DATA = 5'd8,
        S_CMP_A   = 5'd9,
        S_CMP_B   = 5'd10,
        S_BRANCH  = 5'd11,
        S_JUMP    = 5'd12,
        S_PUSH    = 5'd13,
        S_POP     = 5'd14,
        S_RET_LD  = 5'd15,
        S_MOV     = 5'd16,
        S_NOP     = 5'd17
    } state_e;

endpackage

// File: rtl/controller_onehot5to32.sv
// 5-to-32 one-hot decoder for register write enables; all zero when not valid.
module onehot5to32 (
    input  logic [4:0]  idx_i,
    input  logic        valid_i,
    output logic [31:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (valid_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/controller.sv
// Multi-cycle control FSM: the state register is the only flop, all strobes
// are Moore-decoded from that register and the held instruction word.
module controller
    import controller_pkg::*;
#(
    parameter logic [31:0] STACK_TOP = STACK_TOP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] stack,
    input  logic [31:0] comp,
    output logic [31:0] rst,
    output logic [31:0] en,
    output logic [4:0]  sel,
    output logic [4:0]  shamt,
    output logic [3:0]  alu_func,
    output logic [4:0]  state,
    output logic        dne,
    output logic        rw,
    output logic        gtprev,
    output logic        encntr,
    output logic        aluen,
    output logic        jumping,
    output logic        op,
    output logic        compen,
    output logic        compopen,
    output logic        sp_pc,
    output logic        ensp,
    output logic        straddress,
    output logic        ret,
    output logic        dec
);

    state_e      state_q, state_d;
    logic [5:0]  opcode;
    logic [4:0]  fa, fb, fc;
    logic [4:0]  en_idx;
    logic        en_vld;
    logic        unused_bits;

    assign opcode      = instruction[OPC_MSB:OPC_LSB];
    assign fa          = instruction[FA_MSB:FA_LSB];
    assign fb          = instruction[FB_MSB:FB_LSB];
    assign fc          = instruction[FC_MSB:FC_LSB];
    assign shamt       = instruction[SH_MSB:SH_LSB];
    assign state       = state_q;
    assign rst         = (state_q == S_RESET) ? 32'hFFFF_FFFF : 32'h0;
    assign unused_bits = ^{instruction[5:4], comp[31:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel        = 5'd0;
        alu_func   = 4'd0;
        dne        = 1'b0;
        rw         = 1'b0;
        gtprev     = 1'b0;
        encntr     = 1'b0;
        aluen      = 1'b0;
        jumping    = 1'b0;
        op         = 1'b0;
        compen     = 1'b0;
        compopen   = 1'b0;
        sp_pc      = 1'b0;
        ensp       = 1'b0;
        straddress = 1'b0;
        ret        = 1'b0;
        dec        = 1'b0;
        en_idx     = 5'd0;
        en_vld     = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                gtprev = 1'b1;
                encntr = 1'b1;
                // A full stack blocks CALL and an empty stack blocks RET; both degrade to NOP.
                case (opcode)
                    OP_ALU, OP_SHIFT: state_d = S_ALU_A;
                    OP_LOAD:   state_d = S_LD_ADDR;
                    OP_STORE:  state_d = S_ST_ADDR;
                    OP_BRANCH: state_d = S_CMP_A;
                    OP_JMP:    state_d = S_JUMP;
                    OP_CALL:   state_d = (stack == 32'h0) ? S_NOP : S_PUSH;
                    OP_RET:    state_d = (stack == STACK_TOP) ? S_NOP : S_POP;
                    OP_MOV:    state_d = S_MOV;
                    default:   state_d = S_NOP;
                endcase
            end
            S_ALU_A: begin
                sel      = fa;
                alu_func = instruction[FN_MSB:FN_LSB];
                state_d  = (opcode == OP_SHIFT) ? S_ALU_WB : S_ALU_B;
            end
            S_ALU_B: begin
                sel      = fb;
                op       = 1'b1;
                alu_func = instruction[FN_MSB:FN_LSB];
                state_d  = S_ALU_WB;
            end
            S_ALU_WB: begin
                aluen    = 1'b1;
                alu_func = instruction[FN_MSB:FN_LSB];
                en_idx   = fc;
                en_vld   = 1'b1;
                dne      = 1'b1;
                state_d  = S_FETCH;
            end
            S_LD_ADDR, S_ST_ADDR: begin
                sel        = fa;
                straddress = 1'b1;
                state_d    = (state_q == S_LD_ADDR) ? S_LD_DATA : S_ST_DATA;
            end
            S_LD_DATA: begin
                en_idx  = fb;
                en_vld  = 1'b1;
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_ST_DATA: begin
                sel     = fb;
                rw      = 1'b1;
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_CMP_A: begin
                sel      = fa;
                compopen = 1'b1;
                state_d  = S_CMP_B;
            end
            S_CMP_B: begin
                sel     = fb;
                compen  = 1'b1;
                state_d = S_BRANCH;
            end
            S_BRANCH: begin
                sel     = fc;
                jumping = comp[0];
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                sel     = fa;
                jumping = 1'b1;
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_PUSH: begin
                sp_pc   = 1'b1;
                rw      = 1'b1;
                ensp    = 1'b1;
                dec     = 1'b1;
                state_d = S_JUMP;
            end
            S_POP: begin
                sp_pc   = 1'b1;
                ensp    = 1'b1;
                state_d = S_RET_LD;
            end
            S_RET_LD: begin
                sp_pc   = 1'b1;
                ret     = 1'b1;
                jumping = 1'b1;
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_MOV: begin
                sel     = fa;
                en_idx  = fb;
                en_vld  = 1'b1;
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            S_NOP: begin
                dne     = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    onehot5to32 u_en_dec (
        .idx_i    (en_idx),
        .valid_i  (en_vld),
        .onehot_o (en)
    );

endmodule

// File: tb/tb_controller.sv
// Directed bench for the control FSM: expected state sequences are queued
// when an instruction is applied and checked one state per clock.
module tb_controller;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] stack;
    logic [31:0] comp;
    logic [31:0] rst;
    logic [31:0] en;
    logic [4:0]  sel;
    logic [4:0]  shamt;
    logic [3:0]  alu_func;
    logic [4:0]  state;
    logic        dne, rw, gtprev, encntr, aluen, jumping, op;
    logic        compen, compopen, sp_pc, ensp, straddress, ret, dec;

    logic [4:0]  exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    controller #(.STACK_TOP(32'h0000_FFFF)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stack(stack), .comp(comp),
        .rst(rst), .en(en), .sel(sel), .shamt(shamt), .alu_func(alu_func), .state(state),
        .dne(dne), .rw(rw), .gtprev(gtprev), .encntr(encntr), .aluen(aluen),
        .jumping(jumping), .op(op), .compen(compen), .compopen(compopen), .sp_pc(sp_pc),
        .ensp(ensp), .straddress(straddress), .ret(ret), .dec(dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] instr, input int n,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] s3);
        instruction = instr;
        if (n > 0) exp_q.push_back(s0);
        if (n > 1) exp_q.push_back(s1);
        if (n > 2) exp_q.push_back(s2);
        if (n > 3) exp_q.push_back(s3);
    endtask

    task automatic next_state(input string tag);
        logic [4:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed state %0d", tag, state);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_state"}, {27'd0, state}, {27'd0, e});
        end
    endtask

    initial begin
        reset       = 1'b0;
        instruction = 32'h0;
        stack       = 32'h0000_0100;
        comp        = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {27'd0, state}, 32'd0);
        check("reset_rst", rst, 32'hFFFF_FFFF);
        check("reset_en", en, 32'h0);
        check("reset_dne", {31'd0, dne}, 32'd0);

        // LOAD A=1 B=2
        apply(32'h0822_0000, 3, 5'd1, 5'd5, 5'd6, 5'd0);
        reset = 1'b1;
        next_state("ld_fetch");
        check("ld_fetch_strobes", {30'd0, gtprev, encntr}, 32'd3);
        check("ld_fetch_rst", rst, 32'h0);
        next_state("ld_addr");
        check("ld_addr_sel", {27'd0, sel}, 32'd1);
        check("ld_addr_str", {31'd0, straddress}, 32'd1);
        next_state("ld_data");
        check("ld_data_en", en, 32'h4);
        check("ld_data_dne_rw", {30'd0, dne, rw}, 32'd2);

        // MOV A=5 B=17
        apply(32'h28B1_0000, 2, 5'd1, 5'd16, 5'd0, 5'd0);
        next_state("mov_fetch");
        next_state("mov");
        check("mov_sel", {27'd0, sel}, 32'd5);
        check("mov_en", en, 32'h0002_0000);
        check("mov_dne", {31'd0, dne}, 32'd1);

        // ALU A=14 B=8 C=0 funct=0
        apply(32'h01C8_0000, 4, 5'd1, 5'd2, 5'd3, 5'd4);
        next_state("alu_fetch");
        next_state("alu_a");
        check("alu_a_sel", {27'd0, sel}, 32'd14);
        check("alu_a_op", {31'd0, op}, 32'd0);
        next_state("alu_b");
        check("alu_b_sel", {27'd0, sel}, 32'd8);
        check("alu_b_op", {31'd0, op}, 32'd1);
        next_state("alu_wb");
        check("alu_wb_aluen", {31'd0, aluen}, 32'd1);
        check("alu_wb_en", en, 32'h1);
        check("alu_wb_func", {28'd0, alu_func}, 32'd0);
        check("alu_wb_dne", {31'd0, dne}, 32'd1);

        // SHIFT A=2 C=3 shamt=9 funct=7
        apply(32'h0440_1A47, 3, 5'd1, 5'd2, 5'd4, 5'd0);
        next_state("sh_fetch");
        check("sh_fetch_func", {28'd0, alu_func}, 32'd0);
        check("sh_fetch_shamt", {27'd0, shamt}, 32'd9);
        next_state("sh_alu_a");
        check("sh_alu_a_func", {28'd0, alu_func}, 32'd7);
        check("sh_alu_a_sel", {27'd0, sel}, 32'd2);
        next_state("sh_alu_wb");
        check("sh_alu_wb_en", en, 32'h8);

        // BRANCH A=3 B=4 C=5, taken
        comp = 32'h1;
        apply(32'h1064_2800, 4, 5'd1, 5'd9, 5'd10, 5'd11);
        next_state("bt_fetch");
        next_state("bt_cmp_a");
        check("bt_cmp_a_sel", {27'd0, sel}, 32'd3);
        check("bt_cmp_a_open", {30'd0, compopen, compen}, 32'd2);
        next_state("bt_cmp_b");
        check("bt_cmp_b_sel", {27'd0, sel}, 32'd4);
        check("bt_cmp_b_en", {30'd0, compopen, compen}, 32'd1);
        next_state("bt_branch");
        check("bt_branch_sel", {27'd0, sel}, 32'd5);
        check("bt_branch_jump", {30'd0, jumping, dne}, 32'd3);

        // BRANCH not taken
        comp = 32'hFFFF_FFFE;
        apply(32'h1064_2800, 4, 5'd1, 5'd9, 5'd10, 5'd11);
        next_state("bn_fetch");
        next_state("bn_cmp_a");
        next_state("bn_cmp_b");
        next_state("bn_branch");
        check("bn_branch_jump", {30'd0, jumping, dne}, 32'd1);

        // CALL A=7 with room on the stack
        stack = 32'h0000_0100;
        apply(32'h18E0_0000, 3, 5'd1, 5'd13, 5'd12, 5'd0);
        next_state("call_fetch");
        next_state("call_push");
        check("call_push_strobes", {28'd0, sp_pc, rw, ensp, dec}, 32'hF);
        check("call_push_dne", {31'd0, dne}, 32'd0);
        next_state("call_jump");
        check("call_jump_sel", {27'd0, sel}, 32'd7);
        check("call_jump_jd", {30'd0, jumping, dne}, 32'd3);

        // CALL with a full stack
        stack = 32'h0;
        apply(32'h18E0_0000, 2, 5'd1, 5'd17, 5'd0, 5'd0);
        next_state("callf_fetch");
        next_state("callf_nop");
        check("callf_nop_strobes", {27'd0, dne, rw, ensp, jumping, sp_pc}, 32'h10);

        // RET with a non-empty stack
        stack = 32'h0000_0200;
        apply(32'h1C00_0000, 3, 5'd1, 5'd14, 5'd15, 5'd0);
        next_state("ret_fetch");
        next_state("ret_pop");
        check("ret_pop_strobes", {28'd0, sp_pc, ensp, dec, dne}, 32'hC);
        next_state("ret_ld");
        check("ret_ld_strobes", {27'd0, sp_pc, rw, ret, jumping, dne}, 32'h17);

        // RET with an empty stack
        stack = 32'h0000_FFFF;
        apply(32'h1C00_0000, 2, 5'd1, 5'd17, 5'd0, 5'd0);
        next_state("rete_fetch");
        next_state("rete_nop");
        check("rete_nop_dne", {29'd0, dne, ensp, ret}, 32'h4);

        // JMP A=5
        apply(32'h14A0_0000, 2, 5'd1, 5'd12, 5'd0, 5'd0);
        next_state("jmp_fetch");
        next_state("jmp_jump");
        check("jmp_sel", {27'd0, sel}, 32'd5);
        check("jmp_jd", {30'd0, jumping, dne}, 32'd3);

        // STORE A=1 B=2
        apply(32'h0C22_0000, 3, 5'd1, 5'd7, 5'd8, 5'd0);
        next_state("st_fetch");
        next_state("st_addr");
        check("st_addr_sel", {26'd0, sel, straddress}, {26'd0, 5'd1, 1'b1});
        next_state("st_data");
        check("st_data_sel", {27'd0, sel}, 32'd2);
        check("st_data_rwd", {30'd0, rw, dne}, 32'd3);
        check("st_data_en", en, 32'h0);

        // Undefined opcode
        apply(32'hFC00_0000, 2, 5'd1, 5'd17, 5'd0, 5'd0);
        next_state("undef_fetch");
        next_state("undef_nop");
        check("undef_nop_dne", {31'd0, dne}, 32'd1);

        // Reset during ALU_B aborts immediately
        apply(32'h01C8_0000, 3, 5'd1, 5'd2, 5'd3, 5'd0);
        next_state("abort_fetch");
        next_state("abort_alu_a");
        next_state("abort_alu_b");
        reset = 1'b0;
        #1;
        check("abort_state", {27'd0, state}, 32'd0);
        check("abort_en", en, 32'h0);
        check("abort_rst", rst, 32'hFFFF_FFFF);
        check("abort_op_aluen", {30'd0, op, aluen}, 32'd0);
        exp_q.delete();

        @(negedge clk);
        stack = 32'h0000_0100;
        apply(32'h14A0_0000, 2, 5'd1, 5'd12, 5'd0, 5'd0);
        reset = 1'b1;
        next_state("recover_fetch");
        next_state("recover_jump");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/controller.md
# controller

Multi-cycle control FSM of the 32-bit processor. It decodes the current instruction word and sequences register-file, ALU, memory, comparator, stack-pointer and program-counter control strobes over 2–4 clocks per instruction. It sits between the instruction register and the datapath, and exposes its state code for debug.

## Interface
- `STACK_TOP`, default 32'h0000_FFFF: stack-pointer value meaning "stack empty".
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  current instruction word; held stable from FETCH until the cycle after `dne`.
- `stack`  in  32  current stack-pointer value.
- `comp`  in  32  comparator result; bit0 = condition true.
- `rst`  out  32  per-register synchronous clear, one bit per register.
- `en`  out  32  per-register write enable, one-hot.
- `sel`  out  5  register-file read-bus select.
- `shamt`  out  5  shift amount, always equal to instruction[10:6].
- `alu_func`  out  4  ALU function, instruction[3:0] in ALU states, else 0.
- `state`  out  5  current state code.
- `dne`  out  1  last cycle of the instruction.
- `rw`  out  1  memory write (1) / read (0).
- `gtprev`  out  1  latch instruction register.
- `encntr`  out  1  PC increment.
- `aluen`  out  1  ALU result onto write bus.
- `jumping`  out  1  load PC from bus.
- `op`  out  1  ALU operand latch select: 0 = A, 1 = B.
- `compen`  out  1  comparator evaluate.
- `compopen`  out  1  comparator operand-A latch.
- `sp_pc`  out  1  memory address source: 1 = SP, 0 = PC/address register.
- `ensp`  out  1  SP update enable.
- `straddress`  out  1  latch memory address register from bus.
- `ret`  out  1  PC source = memory data (return).
- `dec`  out  1  SP direction: 1 = decrement, 0 = increment.

## Operation
- Fields: opcode [31:26], A [25:21], B [20:16], C [15:11], shamt [10:6], funct [3:0].
- State codes:
  - RESET 0, FETCH 1, ALU_A 2, ALU_B 3, ALU_WB 4.
  - LD_ADDR 5, LD_DATA 6, ST_ADDR 7, ST_DATA 8.
  - CMP_A 9, CMP_B 10, BRANCH 11, JUMP 12.
  - PUSH 13, POP 14, RET_LD 15, MOV 16, NOP 17.
- FETCH outputs: `gtprev`=1, `encntr`=1. It then dispatches on opcode.
- 0x00 ALU, C ← A funct B, 4 cycles:
  - ALU_A: `sel`=A, `op`=0.
  - ALU_B: `sel`=B, `op`=1.
  - ALU_WB: `aluen`=1, `en`[C]=1, `dne`=1.
- 0x01 SHIFT, C ← A shifted by shamt, 3 cycles: ALU_A, then ALU_WB.
- 0x02 LOAD, B ← mem[A], 3 cycles:
  - LD_ADDR: `sel`=A, `straddress`=1.
  - LD_DATA: `rw`=0, `en`[B]=1, `dne`=1.
- 0x03 STORE, mem[A] ← B, 3 cycles:
  - ST_ADDR: as LD_ADDR.
  - ST_DATA: `sel`=B, `rw`=1, `dne`=1.
- 0x04 BRANCH, 4 cycles:
  - CMP_A: `sel`=A, `compopen`=1.
  - CMP_B: `sel`=B, `compen`=1.
  - BRANCH: `sel`=C, `jumping`=comp[0], `dne`=1.
- 0x05 JMP, 2 cycles. JUMP: `sel`=A, `jumping`=1, `dne`=1.
- 0x06 CALL, 3 cycles:
  - PUSH: `sp_pc`=1, `rw`=1, `ensp`=1, `dec`=1.
  - JUMP.
- 0x07 RET, 3 cycles:
  - POP: `sp_pc`=1, `ensp`=1, `dec`=0.
  - RET_LD: `sp_pc`=1, `rw`=0, `ret`=1, `jumping`=1, `dne`=1.
- 0x0A MOV, B ← A, 2 cycles. MOV: `sel`=A, `en`[B]=1, `dne`=1.
- Any other opcode: NOP, 2 cycles. NOP state: `dne`=1 only.
- Stack boundaries:
  - CALL with `stack`==0 (full): executes as NOP, no push, no jump.
  - RET with `stack`==`STACK_TOP` (empty): executes as NOP.
- Every output not listed for a state is 0.
- `en` is at most one-hot. Writing to register 0 is allowed.

## Timing
- Reset low, asynchronous: `state`=RESET and `rst`=32'hFFFF_FFFF; every other output is 0 except `shamt`.
- First rising edge with reset high: RESET → FETCH.
- Moore outputs, decoded combinationally from the state register and `instruction`. The state register is the only flop.
- After a state with `dne`=1, the next edge → FETCH.
- Latency in clocks, FETCH inclusive: ALU 4, SHIFT 3, LOAD 3, STORE 3, BRANCH 4, JMP 2, CALL 3, RET 3, MOV 2, NOP 2.
- `comp` is sampled only in BRANCH.
- `stack` is sampled only in FETCH, for the dispatch decision.
- Reset asserted mid-instruction aborts immediately to RESET. No partial-write strobe may remain.

## Structure
- Package `controller_pkg`: opcode constants, 5-bit state enum with the codes above, field bit positions, `STACK_TOP` default.
- One sub-module, `onehot5to32`, combinational decoder used for `en`.

## Test plan
- Reset low for 2 clocks → `state`=0, `rst`=FFFFFFFF, `en`=0. Release with `instruction`=32'h08220000 (LOAD, A=1, B=2): states 1, 5, 6. In LD_ADDR, `sel`=1 and `straddress`=1. In LD_DATA, `en`=32'h4 and `dne`=1.
- 32'h28B10000 (MOV, A=5, B=17): states 1, 16. In MOV, `sel`=5, `en`=32'h0002_0000, `dne`=1.
- 32'h01C80000 (ALU): states 1, 2, 3, 4 with `sel` 14 then 8. In ALU_WB, `aluen`=1, `en`=32'h1, `alu_func`=0.
- 32'h10642800 (BRANCH, A=3, B=4, C=5):
  - `comp`=1 → in BRANCH, `sel`=5 and `jumping`=1.
  - `comp`=0 → `jumping`=0 and `dne`=1.
- CALL (opcode 0x06):
  - `stack`=0x100 → PUSH with `rw`=1, `ensp`=1, `dec`=1, then JUMP.
  - `stack`=0 → FETCH, NOP.
- Assert reset during ALU_B → `state`=0 immediately, `en`=0, `rst`=FFFFFFFF.
